// File: rtl/rfile_sb_if.sv
// Register-file bus: read ports, issue strobe, writeback and scoreboard status.
// slave = register file side, master = pipeline side driving reads/issue/writeback.
interface rfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [ADDR_W:0]       pend_cnt;
    logic                  sb_err;

    modport master (
        output rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        input  rd_data, rd_busy, pend_cnt, sb_err
    );

    modport slave (
        input  rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        output rd_data, rd_busy, pend_cnt, sb_err
    );
endinterface

// File: rtl/rfile_sb.sv
// Multi-read-port register file with per-register pending (RAW scoreboard) bits.
// Ports: clk, rst (sync, active-high), bus (rfile_sb_if.slave): NRD combinational
// read ports with busy flags, issue strobe, writeback, pend_cnt, sticky sb_err.
// Optional macro RFILE_SB_BYPASS_EN: same-cycle write-through to the read ports.
module rfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input logic       clk,
    input logic       rst,
    rfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              err;
    logic              err_nxt;
    logic              wr_ok;
    logic              iss_ok;

    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_busy_c;

    // Register 0 swallows writes and issues when hard-wired to zero.
    assign wr_ok  = bus.wr_en &&
                    !(ZERO_REG != 0 && bus.wr_addr == '0);
    assign iss_ok = bus.iss_en &&
                    !(ZERO_REG != 0 && bus.iss_addr == '0);

    // Issue is applied after writeback so a same-cycle new producer wins.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok)
            pend_nxt[bus.wr_addr] = 1'b0;
        if (iss_ok)
            pend_nxt[bus.iss_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
    end

    // Double issue without an intervening writeback, or a writeback that has
    // no earlier issue (same-cycle issue does not count) are protocol errors.
    always_comb begin
        err_nxt = err;
        if (iss_ok && pend[bus.iss_addr] &&
            !(wr_ok && bus.wr_addr == bus.iss_addr))
            err_nxt = 1'b1;
        if (wr_ok && !pend[bus.wr_addr])
            err_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            if (wr_ok)
                mem[bus.wr_addr] <= bus.wr_data;
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
            err  <= err_nxt;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [ADDR_W-1:0] ra;
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            rd_data_c[k*DATA_W +: DATA_W] = mem[ra];
            rd_busy_c[k] = pend[ra];
`ifdef RFILE_SB_BYPASS_EN
            if (wr_ok && bus.wr_addr == ra) begin
                rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
                if (!(iss_ok && bus.iss_addr == ra))
                    rd_busy_c[k] = 1'b0;
            end
`endif
            // Explicit mux keeps r0 at zero even before the first reset.
            if (ZERO_REG != 0 && ra == '0) begin
                rd_data_c[k*DATA_W +: DATA_W] = '0;
                rd_busy_c[k] = 1'b0;
            end
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.pend_cnt = cnt;
    assign bus.sb_err   = err;
endmodule

// File: tb/tb_rfile_sb.sv
// Directed testbench for rfile_sb (DATA_W=32, ADDR_W=5, NRD=2, ZERO_REG=1).
// Expectations follow RFILE_SB_BYPASS_EN when the macro is defined for the build.
module tb_rfile_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bif ();

    rfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.iss_en   = 1'b0;
        bif.iss_addr = '0;
        bif.wr_en    = 1'b0;
        bif.wr_addr  = '0;
        bif.wr_data  = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bif.rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        set_rd(5'd0, 5'd0);
        checks++;
        if (bif.rd_data !== 64'h0 || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_state data=%h busy=%b exp 0/00",
                     bif.rd_data, bif.rd_busy);
        end
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
        bif.iss_en = 1'b1; bif.iss_addr = 5'd5;
        tick();
        idle();
        bif.wr_en = 1'b1; bif.wr_addr = 5'd5; bif.wr_data = 32'hDEADBEEF;
        tick();
        idle();
        set_rd(5'd5, 5'd6);
        checks++;
        if (bif.rd_data[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_r5 got %h exp deadbeef", bif.rd_data[31:0]);
        end
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL load_status cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
        rst = 1'b1;
        bif.wr_en = 1'b1; bif.wr_addr = 5'd6; bif.wr_data = 32'h66;
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (bif.rd_data !== 64'h0 || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL after_reset data=%h busy=%b exp 0/00",
                     bif.rd_data, bif.rd_busy);
        end
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_status cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
    endtask

    task automatic test_issue_wb();
        set_rd(5'd3, 5'd3);
        bif.iss_en = 1'b1; bif.iss_addr = 5'd3;
        tick();
        idle();
        #1;
        checks++;
        if (bif.rd_busy !== 2'b11 || bif.pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL issue_c1 busy=%b cnt=%0d exp 11/1",
                     bif.rd_busy, bif.pend_cnt);
        end
        tick();
        checks++;
        if (bif.rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL issue_c2 busy=%b exp 1", bif.rd_busy[0]);
        end
        bif.wr_en = 1'b1; bif.wr_addr = 5'd3; bif.wr_data = 32'h1234;
        tick();
        idle();
        #1;
        checks++;
        if (bif.rd_data[31:0] !== 32'h1234 || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL wb_r3 data=%h busy=%b exp 1234/00",
                     bif.rd_data[31:0], bif.rd_busy);
        end
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL wb_status cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
    endtask

    task automatic test_same_cycle();
        set_rd(5'd7, 5'd3);
        bif.iss_en = 1'b1; bif.iss_addr = 5'd7;
        tick();
        bif.wr_en = 1'b1; bif.wr_addr = 5'd7; bif.wr_data = 32'h7777;
        tick();
        idle();
        #1;
        checks++;
        if (bif.rd_data[31:0] !== 32'h7777 || bif.rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL same_r7 data=%h busy=%b exp 7777/1",
                     bif.rd_data[31:0], bif.rd_busy[0]);
        end
        checks++;
        if (bif.rd_data[63:32] !== 32'h1234 || bif.rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL port1_r3 data=%h busy=%b exp 1234/0",
                     bif.rd_data[63:32], bif.rd_busy[1]);
        end
        checks++;
        if (bif.pend_cnt !== 6'd1 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL same_status cnt=%0d err=%b exp 1/0",
                     bif.pend_cnt, bif.sb_err);
        end
        bif.wr_en = 1'b1; bif.wr_addr = 5'd7; bif.wr_data = 32'h0;
        tick();
        idle();
        #1;
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL r7_drain cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
    endtask

    task automatic test_zero_reg();
        set_rd(5'd0, 5'd0);
        bif.wr_en = 1'b1; bif.wr_addr = 5'd0; bif.wr_data = 32'hFFFFFFFF;
        bif.iss_en = 1'b1; bif.iss_addr = 5'd0;
        #1;
        checks++;
        if (bif.rd_data !== 64'h0 || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL r0_same data=%h busy=%b exp 0/00",
                     bif.rd_data, bif.rd_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bif.rd_data !== 64'h0 || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL r0_after data=%h busy=%b exp 0/00",
                     bif.rd_data, bif.rd_busy);
        end
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL r0_status cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
    endtask

    task automatic test_bypass();
        set_rd(5'd4, 5'd4);
        bif.iss_en = 1'b1; bif.iss_addr = 5'd4;
        tick();
        idle();
        bif.wr_en = 1'b1; bif.wr_addr = 5'd4; bif.wr_data = 32'hA5A5;
        #1;
`ifdef RFILE_SB_BYPASS_EN
        checks++;
        if (bif.rd_data !== {2{32'hA5A5}} || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL bypass data=%h busy=%b exp a5a5x2/00",
                     bif.rd_data, bif.rd_busy);
        end
`else
        checks++;
        if (bif.rd_data !== 64'h0 || bif.rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL no_bypass data=%h busy=%b exp 0/11",
                     bif.rd_data, bif.rd_busy);
        end
`endif
        tick();
        idle();
        #1;
        checks++;
        if (bif.rd_data !== {2{32'hA5A5}} || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL r4_after data=%h busy=%b exp a5a5x2/00",
                     bif.rd_data, bif.rd_busy);
        end
        checks++;
        if (bif.pend_cnt !== 6'd0 || bif.sb_err !== 1'b0) begin
            errors++;
            $display("FAIL r4_status cnt=%0d err=%b exp 0/0",
                     bif.pend_cnt, bif.sb_err);
        end
    endtask

    task automatic test_sb_err();
        bif.iss_en = 1'b1; bif.iss_addr = 5'd9;
        tick();
        #1;
        checks++;
        if (bif.sb_err !== 1'b0 || bif.pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL first_iss err=%b cnt=%0d exp 0/1",
                     bif.sb_err, bif.pend_cnt);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bif.sb_err !== 1'b1 || bif.pend_cnt !== 6'd1) begin
            errors++;
            $display("FAIL double_iss err=%b cnt=%0d exp 1/1",
                     bif.sb_err, bif.pend_cnt);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bif.sb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky err=%b exp 1", bif.sb_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bif.sb_err !== 1'b0 || bif.pend_cnt !== 6'd0) begin
            errors++;
            $display("FAIL err_clear err=%b cnt=%0d exp 0/0",
                     bif.sb_err, bif.pend_cnt);
        end
        bif.wr_en = 1'b1; bif.wr_addr = 5'd10; bif.wr_data = 32'hBEEF;
        tick();
        idle();
        set_rd(5'd10, 5'd9);
        checks++;
        if (bif.sb_err !== 1'b1) begin
            errors++;
            $display("FAIL wr_unissued err=%b exp 1", bif.sb_err);
        end
        checks++;
        if (bif.rd_data[31:0] !== 32'hBEEF || bif.rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL wr_unissued_data data=%h busy=%b exp beef/00",
                     bif.rd_data[31:0], bif.rd_busy);
        end
    endtask

    initial begin
        idle();
        bif.rd_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_issue_wb();
        test_same_cycle();
        test_zero_reg();
        test_bypass();
        test_sb_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
